// File: rtl/su_fetch_seq.sv
// MX11SU instruction fetch/issue sequencer: fetches one byte per instruction over a
// req/ack port, then drives the decoder through one INC cycle and one EXEC cycle.
module su_fetch_seq #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              halt,
    input  logic [ADDR_W-1:0] insp,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              fetch,
    output logic              ce_n,
    output logic [7:0]        insr,
    output logic              busy,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_INC  = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          ir_q, ir_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_req_q, mem_req_d;
    logic                fetch_q, fetch_d;
    logic                ce_n_q, ce_n_d;
    logic [7:0]          insr_q, insr_d;
    logic                busy_q, busy_d;

    // Next-state logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            S_IDLE: begin
                if (run && !halt) begin
                    state_d    = S_REQ;
                    mem_addr_d = insp;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_INC;
                    ir_d    = mem_rdata;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_INC: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // insp already carries any jump target written during EXEC
                if (run && !halt) begin
                    state_d    = S_REQ;
                    mem_addr_d = insp;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d = (state_d == S_REQ);
        fetch_d   = (state_d == S_INC);
        ce_n_d    = !((state_d == S_INC) || (state_d == S_EXEC));
        busy_d    = (state_d != S_IDLE);
        if (state_d == S_EXEC) begin
            insr_d = ir_d;
        end else begin
            insr_d = 8'h00;
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= 8'h00;
            retired_q  <= {CNT_W{1'b0}};
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_req_q  <= 1'b0;
            fetch_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            insr_q     <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            fetch_q    <= fetch_d;
            ce_n_q     <= ce_n_d;
            insr_q     <= insr_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign fetch    = fetch_q;
    assign ce_n     = ce_n_q;
    assign insr     = insr_q;
    assign busy     = busy_q;
    assign retired  = retired_q;

endmodule

// File: doc/su_fetch_seq.md
Name: su_fetch_seq

Overview:
- Instruction fetch/issue sequencer for the MX11SU. It is the driving end of the SU instruction-decode interface.
- Reads instruction bytes from instruction memory at the current INSP through a req/ack handshake and holds each byte in an internal instruction register (IR).
- Sequences the decoder through one fetch (INSP-increment) cycle and one execute cycle per instruction, using `fetch`, `ce_n` and `insr`.
- Sits between instruction memory, the INSP register in the datapath, and the ISA decode ROM.

Parameters:
- ADDR_W, 8, width of the instruction address (INSP) and `mem_addr`.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; 1 = sequencer may start new instructions.
- halt  input  1  level; 1 = stop after the current instruction completes.
- insp  input  ADDR_W  current INSP value from the datapath.
- mem_req  output  1  instruction read request.
- mem_addr  output  ADDR_W  read address; held stable while `mem_req` is 1.
- mem_ack  input  1  read complete; `mem_rdata` is valid in the same cycle.
- mem_rdata  input  8  instruction byte.
- fetch  output  1  decoder fetch strobe (INSP-increment micro-op).
- ce_n  output  1  decoder chip enable, active low.
- insr  output  8  instruction byte presented to the decoder.
- busy  output  1  1 in every state except IDLE.
- retired  output  CNT_W  count of completed EXEC cycles.

Behaviour:
- Reset (synchronous; overrides every other input in that cycle):
  - state = IDLE, IR = 8'h00, retired = 0.
  - mem_req = 0, mem_addr = 0, fetch = 0, ce_n = 1, insr = 8'h00, busy = 0.
- All outputs are registered. No combinational path from any input to any output.
- States and their outputs: IDLE, REQ, INC, EXEC.
  - IDLE: ce_n = 1, fetch = 0, mem_req = 0.
    - If run = 1 and halt = 0, go to REQ next cycle.
    - Otherwise remain in IDLE.
  - REQ: mem_req = 1, mem_addr = insp sampled on entry (held constant until ack), ce_n = 1, fetch = 0.
    - Stay in REQ while mem_ack = 0. There is no timeout.
    - On mem_ack = 1: IR <= mem_rdata, mem_req drops next cycle, go to INC.
  - INC: exactly one cycle with fetch = 1, ce_n = 0, insr = 8'h00. The decoder performs INSP <= INSP+1.
    - Always go to EXEC.
  - EXEC: exactly one cycle with ce_n = 0, fetch = 0, insr = IR.
    - retired increments at the end of EXEC and wraps from all-ones to 0.
    - IR = 8'h00 (NOP) still counts as retired.
    - Next state: REQ if run = 1 and halt = 0 (sampled in EXEC); otherwise IDLE.
- insr is 8'h00 in every state except EXEC. ce_n is 1 in IDLE and REQ.
- fetch and ce_n = 0 are never asserted to the decoder together with a non-zero insr.
- Latency:
  - From IDLE with run rising at edge N: mem_req = 1 after edge N+1.
  - With zero-wait memory (ack in the first REQ cycle): REQ, INC, EXEC = 3 cycles per instruction in steady state.
- halt or run = 0 asserted during REQ, INC or EXEC: the current instruction completes (ack, INC, EXEC), then IDLE. A started fetch is never abandoned.
- mem_ack while not in REQ: ignored. IR and state are unchanged.
- insp changes while in REQ: mem_addr does not change.
- Jumps: the datapath updates INSP during EXEC. The next REQ samples the updated insp on entry, so no extra bubble is inserted.
- Reset mid-REQ: mem_req = 0 after that edge. A later stale mem_ack in IDLE is ignored.

Test Plan:
- Reset: hold rst 2 cycles with run = 1 → mem_req = 0, ce_n = 1, fetch = 0, insr = 00, retired = 0, busy = 0. First mem_req = 1 at the 2nd edge after rst falls.
- Zero-wait stream: memory acks immediately with bytes 8'h81, 8'h05, 8'hA9, insp = 0x10, 0x11, 0x12 → mem_addr = 0x10/0x11/0x12; fetch pulses exactly one cycle each; insr = 81, 05, A9 in EXEC cycles spaced 3 cycles apart; retired = 3.
- Wait states: ack delayed 4 cycles → mem_req and mem_addr stay stable for 5 cycles; fetch = 0 and ce_n = 1 throughout; then INC then EXEC with the correct byte.
- Halt mid-fetch: assert halt in the 2nd REQ wait cycle → the instruction still completes (INC, EXEC), then IDLE with busy = 0 and retired incremented by 1. Release halt → next REQ follows.
- Stray ack and reset mid-REQ: pulse mem_ack in IDLE → no state change. Assert rst during REQ → mem_req = 0 next cycle; an ack in the following cycle is ignored and retired stays 0.
- Counter wrap: with CNT_W = 4, run 17 NOP (8'h00) instructions → retired = 1 after wrap; insr = 00 in every EXEC.
